hazard_resolve: RTL



---
 rtl/hazard_resolve.sv | 120 ++++++++++++
 1 files changed

// File: rtl/hazard_resolve.sv
// Hazard-unit consumer for the non-forwarding 5-stage pipeline: drives PC and
// pipeline-register enables/flushes, tracks state, counts stalls/flushes, and runs a stall watchdog.
module hazard_resolve #(
    parameter int CNT_W     = 32,
    parameter int RUN_W     = 4,
    parameter int STALL_MAX = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       hazard_op_i,
    input  logic             clr_cnt_i,
    output logic             pc_en_o,
    output logic             if_id_en_o,
    output logic             if_id_flush_o,
    output logic             id_ex_flush_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic [CNT_W-1:0] flush_count_o,
    output logic [RUN_W-1:0] max_stall_o,
    output logic             stall_timeout_o,
    output logic             illegal_op_o
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_MAX = {RUN_W{1'b1}};
    localparam logic [RUN_W-1:0] RUN_LIM = RUN_W'(STALL_MAX);

    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_len_q, run_len_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [RUN_W-1:0] max_stall_q, max_stall_d;
    logic             timeout_q, timeout_d;
    logic             illegal_q, illegal_d;

    logic is_stall, is_flush, is_illegal;

    assign is_stall   = (hazard_op_i == 2'd1) || (hazard_op_i == 2'd3);
    assign is_flush   = (hazard_op_i == 2'd2);
    assign is_illegal = (hazard_op_i == 2'd3);

    // Mealy controls: the registered state never feeds back into them.
    always_comb begin
        pc_en_o       = 1'b1;
        if_id_en_o    = 1'b1;
        if_id_flush_o = 1'b0;
        id_ex_flush_o = 1'b0;
        if (rst_i) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end else if (is_stall) begin
            pc_en_o       = 1'b0;
            if_id_en_o    = 1'b0;
            id_ex_flush_o = 1'b1;
        end else if (is_flush) begin
            if_id_flush_o = 1'b1;
            id_ex_flush_o = 1'b1;
        end
    end

    always_comb begin
        state_d     = is_stall ? ST_STALL : (is_flush ? ST_FLUSH : ST_RUN);
        run_len_d   = '0;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        timeout_d   = timeout_q;
        illegal_d   = illegal_q || is_illegal;
        if (is_stall) begin
            run_len_d = (run_len_q == RUN_MAX) ? run_len_q : run_len_q + RUN_W'(1);
            if (stall_cnt_q != CNT_MAX) stall_cnt_d = stall_cnt_q + CNT_W'(1);
            if (run_len_q == RUN_LIM) timeout_d = 1'b1;
        end
        if (is_flush && flush_cnt_q != CNT_MAX) flush_cnt_d = flush_cnt_q + CNT_W'(1);
        max_stall_d = (run_len_d > max_stall_q) ? run_len_d : max_stall_q;
        // Clear wins over any same-edge increment/set but leaves run_len and state alone.
        if (clr_cnt_i) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
            max_stall_d = '0;
            timeout_d   = 1'b0;
            illegal_d   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_RUN;
            run_len_q   <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            max_stall_q <= '0;
            timeout_q   <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_len_q   <= run_len_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            max_stall_q <= max_stall_d;
            timeout_q   <= timeout_d;
            illegal_q   <= illegal_d;
        end
    end

    assign state_o         = state_q;
    assign stall_cycles_o  = stall_cnt_q;
    assign flush_count_o   = flush_cnt_q;
    assign max_stall_o     = max_stall_q;
    assign stall_timeout_o = timeout_q;
    assign illegal_op_o    = illegal_q;

endmodule
